// File: rtl/if_id_hazard.sv
// if_id_hazard: IF/ID pipeline register with load-use hazard detection
// and branch flush control.
// Optional build macro: STALL_COUNT_EN adds a 32-bit cumulative stall
// counter on the StallCount port.
module if_id_hazard #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] PCPlus4In,
    input  logic [DATA_W-1:0] InstrIn,
    input  logic              IdExMemRead,
    input  logic [4:0]        IdExRt,
    input  logic              BranchTaken,
    output logic [DATA_W-1:0] PCPlus4Out,
    output logic [DATA_W-1:0] InstrOut,
    output logic              ValidOut,
    output logic              PCWrite,
`ifdef STALL_COUNT_EN
    output logic              Bubble,
    output logic [31:0]       StallCount
`else
    output logic              Bubble
`endif
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic       hazard;

    // Conservative load-use check: both source fields are compared
    // whatever the opcode; $zero is never a real producer.
    always_comb begin
        rs      = InstrOut[25:21];
        rt      = InstrOut[20:16];
        hazard  = ValidOut & IdExMemRead & (IdExRt != 5'd0) &
                  ((IdExRt == rs) | (IdExRt == rt));
        PCWrite = ~hazard;
        Bubble  = hazard;
    end

    // Pipeline register: stall holds, branch squashes, otherwise capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrOut   <= NOP_INSTR;
            PCPlus4Out <= '0;
            ValidOut   <= 1'b0;
        end else if (hazard) begin
            InstrOut   <= InstrOut;
            PCPlus4Out <= PCPlus4Out;
            ValidOut   <= ValidOut;
        end else if (BranchTaken) begin
            InstrOut   <= NOP_INSTR;
            PCPlus4Out <= '0;
            ValidOut   <= 1'b0;
        end else begin
            InstrOut   <= InstrIn;
            PCPlus4Out <= PCPlus4In;
            ValidOut   <= 1'b1;
        end
    end

`ifdef STALL_COUNT_EN
    // Cumulative stall cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (hazard) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard with an expected-register scoreboard.
module tb_if_id_hazard;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] PCPlus4In;
    logic [DATA_W-1:0] InstrIn;
    logic              IdExMemRead;
    logic [4:0]        IdExRt;
    logic              BranchTaken;
    logic [DATA_W-1:0] PCPlus4Out;
    logic [DATA_W-1:0] InstrOut;
    logic              ValidOut;
    logic              PCWrite;
    logic              Bubble;
`ifdef STALL_COUNT_EN
    logic [31:0]       StallCount;
`endif

    if_id_hazard #(.DATA_W(DATA_W), .NOP_INSTR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCPlus4In   (PCPlus4In),
        .InstrIn     (InstrIn),
        .IdExMemRead (IdExMemRead),
        .IdExRt      (IdExRt),
        .BranchTaken (BranchTaken),
        .PCPlus4Out  (PCPlus4Out),
        .InstrOut    (InstrOut),
        .ValidOut    (ValidOut),
        .PCWrite     (PCWrite),
`ifdef STALL_COUNT_EN
        .Bubble      (Bubble),
        .StallCount  (StallCount)
`else
        .Bubble      (Bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.valid = valid;
        q.push_back(e);
    endtask

    // Clock one edge, then compare the registered outputs to the oldest expectation.
    task automatic edge_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_empty observed=0 expected=1", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_instr"}, InstrOut, e.instr);
            chk({tag, "_pc"}, PCPlus4Out, e.pc);
            chk({tag, "_valid"}, {31'd0, ValidOut}, {31'd0, e.valid});
        end
    endtask

    task automatic comb_check(input string tag, input logic pcw, input logic bub);
        chk({tag, "_pcwrite"}, {31'd0, PCWrite}, {31'd0, pcw});
        chk({tag, "_bubble"}, {31'd0, Bubble}, {31'd0, bub});
    endtask

    initial begin
        rst = 1'b1;
        PCPlus4In = '0;
        InstrIn = 32'h0123_4567;
        IdExMemRead = 1'b0;
        IdExRt = 5'd0;
        BranchTaken = 1'b0;
        #12;
        chk("rst_instr", InstrOut, 32'h0);
        chk("rst_valid", {31'd0, ValidOut}, 32'd0);
        comb_check("rst", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Pass-through: Rs=9, Rt=10
        InstrIn = 32'h012A_4020;
        PCPlus4In = 32'h8;
        push(32'h012A_4020, 32'h8, 1'b1);
        edge_check("pass");
        comb_check("pass", 1'b1, 1'b0);

        // Load-use on Rs: hold for one cycle
        @(negedge clk);
        InstrIn = 32'h1111_1111;
        PCPlus4In = 32'hC;
        IdExMemRead = 1'b1;
        IdExRt = 5'd9;
        #1;
        comb_check("lu_rs", 1'b0, 1'b1);
        push(32'h012A_4020, 32'h8, 1'b1);
        edge_check("lu_hold");
        @(negedge clk);
        IdExMemRead = 1'b0;
        #1;
        comb_check("lu_release", 1'b1, 1'b0);
        push(32'h1111_1111, 32'hC, 1'b1);
        edge_check("lu_load");

        // Load-use on Rt: 0x11111111 has Rs=8, Rt=17
        @(negedge clk);
        InstrIn = 32'h0000_4020;
        PCPlus4In = 32'h10;
        IdExMemRead = 1'b1;
        IdExRt = 5'd17;
        #1;
        comb_check("lu_rt", 1'b0, 1'b1);
        push(32'h1111_1111, 32'hC, 1'b1);
        edge_check("lu_rt_hold");

        // Non-matching producer does not stall
        @(negedge clk);
        IdExRt = 5'd5;
        #1;
        comb_check("no_match", 1'b1, 1'b0);
        push(32'h0000_4020, 32'h10, 1'b1);
        edge_check("no_match");

        // $zero exclusion: Rs=Rt=0 and IdExRt=0
        @(negedge clk);
        IdExRt = 5'd0;
        #1;
        comb_check("zero", 1'b1, 1'b0);

        // Branch flush alone
        IdExMemRead = 1'b0;
        BranchTaken = 1'b1;
        InstrIn = 32'hDEAD_BEEF;
        PCPlus4In = 32'h14;
        push(32'h0, 32'h0, 1'b0);
        edge_check("flush");

        // Refill, then branch together with a hazard: hold, no flush
        @(negedge clk);
        BranchTaken = 1'b0;
        InstrIn = 32'h012A_4020;
        PCPlus4In = 32'h18;
        push(32'h012A_4020, 32'h18, 1'b1);
        edge_check("refill");
        @(negedge clk);
        BranchTaken = 1'b1;
        IdExMemRead = 1'b1;
        IdExRt = 5'd10;
        InstrIn = 32'h0BAD_0BAD;
        PCPlus4In = 32'h1C;
        #1;
        comb_check("br_haz", 1'b0, 1'b1);
        push(32'h012A_4020, 32'h18, 1'b1);
        edge_check("br_haz_hold");

`ifdef STALL_COUNT_EN
        chk("stall_count", StallCount, 32'd3);
`endif

        // Reset in the middle of a stall
        @(negedge clk);
        BranchTaken = 1'b0;
        InstrIn = 32'h0123_4567;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_instr", InstrOut, 32'h0);
        chk("rst_mid_pc", PCPlus4Out, 32'h0);
        chk("rst_mid_valid", {31'd0, ValidOut}, 32'd0);
        comb_check("rst_mid", 1'b1, 1'b0);
`ifdef STALL_COUNT_EN
        chk("rst_mid_count", StallCount, 32'd0);
`endif
        chk("sb_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
